multi_timer: RTL

- Parametrised successor to the single-channel bus timer.
- N_CH independent down-counting channels behind one word-addressed register window on the bridge/device bus.
- Per channel: one-shot or auto-reload mode, a sticky pending flag with write-1-to-clear, and an interrupt mask.
- Drives a per-channel IRQ vector and an OR-reduced IRQ into CP0 hardware interrupt inputs.

---
 rtl/multi_timer_pkg.sv | 24 ++
 rtl/timer_channel.sv | 137 +++++++++++++
 rtl/multi_timer.sv | 68 ++++++
 3 files changed

// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: register map, CTRL layout,
// mode encodings and the per-channel FSM state type.
package multi_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_PS_LSB   = 8;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    INT  = 2'd2
  } state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/PENDING registers and the IDLE/CNT/INT FSM.
// Latency: registers update at the write edge; no backpressure (writes always accepted).
// MULTI_TIMER_PRESCALE_EN adds the CTRL[15:8] prescaler.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_we,
  input  logic             preset_we,
  input  logic             status_we,
  input  logic [31:0]      din,
  output logic [31:0]      ctrl,
  output logic [CNT_W-1:0] preset,
  output logic [CNT_W-1:0] count,
  output logic             pending
);

  state_t           state, state_n;
  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic [CNT_W-1:0] count_n;
  logic             pend_set;
  logic             en_clr;
  logic             tick;
  logic [7:0]       ps;
  logic             unused_din;

  assign unused_din = ^din;

`ifdef MULTI_TIMER_PRESCALE_EN
  logic [7:0] pscnt, pscnt_n;

  // Outside CNT the prescaler sits at PS, so every load starts a full PS+1 period.
  always_comb begin
    pscnt_n = pscnt;
    if (state != CNT)
      pscnt_n = ps;
    else if (en)
      pscnt_n = tick ? ps : pscnt - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ps    <= 8'd0;
      pscnt <= 8'd0;
    end else begin
      if (ctrl_we)
        ps <= din[CTRL_PS_LSB +: 8];
      pscnt <= pscnt_n;
    end
  end

  assign tick = (pscnt == 8'd0);
`else
  assign ps   = 8'd0;
  assign tick = 1'b1;
`endif

  always_comb begin
    state_n  = state;
    count_n  = count;
    pend_set = 1'b0;
    en_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          count_n = preset;
          state_n = CNT;
        end
      end
      CNT: begin
        if (!en) begin
          state_n = IDLE;
        end else if (tick) begin
          if (count <= CNT_W'(1)) begin
            count_n  = '0;
            pend_set = 1'b1;
            state_n  = INT;
          end else begin
            count_n = count - CNT_W'(1);
          end
        end
      end
      INT: begin
        if (mode == MODE_RELOAD && en) begin
          count_n = preset;
          state_n = CNT;
        end else begin
          en_clr  = (mode != MODE_RELOAD);
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      en      <= 1'b0;
      mode    <= MODE_ONESHOT;
      im      <= 1'b0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      // A software CTRL write in the expiry cycle overrides the one-shot auto-clear.
      if (ctrl_we) begin
        en   <= din[CTRL_EN];
        mode <= din[CTRL_MODE_LSB +: 2];
        im   <= din[CTRL_IM];
      end else if (en_clr) begin
        en <= 1'b0;
      end
      if (preset_we)
        preset <= din[CNT_W-1:0];
      pending <= pend_set | (pending & ~(status_we & din[0]));
    end
  end

  always_comb begin
    ctrl                        = '0;
    ctrl[CTRL_EN]               = en;
    ctrl[CTRL_MODE_LSB +: 2]    = mode;
    ctrl[CTRL_IM]               = im;
`ifdef MULTI_TIMER_PRESCALE_EN
    ctrl[CTRL_PS_LSB +: 8]      = ps;
`endif
  end

endmodule

// File: rtl/multi_timer.sv
// N_CH-channel down-counting timer behind a word-addressed register window.
// Latency: writes take effect at the edge, reads and IRQ are combinational; no backpressure.
// MULTI_TIMER_PRESCALE_EN enables the per-channel CTRL[15:8] prescaler.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter  int N_CH  = 2,
  parameter  int CNT_W = 32,
  localparam int CH_AW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH_AW+3:2]  addr,
  input  logic              WE,
  input  logic [31:0]       din,
  output logic [31:0]       dataOut,
  output logic              IRQ,
  output logic [N_CH-1:0]   irq_vec
);

  logic [CH_AW-1:0] ch_sel;
  logic [1:0]       reg_sel;
  logic [31:0]      ctrl_rd   [N_CH];
  logic [CNT_W-1:0] preset_rd [N_CH];
  logic [CNT_W-1:0] count_rd  [N_CH];
  logic [N_CH-1:0]  pending;

  assign ch_sel  = addr[CH_AW+3:4];
  assign reg_sel = addr[3:2];

  // Channels at or beyond N_CH never match, so their writes drop and reads return 0.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = WE && (ch_sel == CH_AW'(i));

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .ctrl_we   (hit && (reg_sel == REG_CTRL)),
      .preset_we (hit && (reg_sel == REG_PRESET)),
      .status_we (hit && (reg_sel == REG_STATUS)),
      .din       (din),
      .ctrl      (ctrl_rd[i]),
      .preset    (preset_rd[i]),
      .count     (count_rd[i]),
      .pending   (pending[i])
    );

    assign irq_vec[i] = pending[i] & ctrl_rd[i][CTRL_IM];
  end

  assign IRQ = |irq_vec;

  always_comb begin
    dataOut = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_AW'(i)) begin
        case (reg_sel)
          REG_CTRL:   dataOut = ctrl_rd[i];
          REG_PRESET: dataOut = 32'(preset_rd[i]);
          REG_COUNT:  dataOut = 32'(count_rd[i]);
          default:    dataOut = {31'd0, pending[i]};
        endcase
      end
    end
  end

endmodule
